sm83_bus_unit: RTL and testbench

Bus and fetch unit for the SM83 core. It sits directly downstream of the `control` sequencer and consumes its per-cycle strobes (`addr_sel`, `inc_pc`, `mem_to_*`, `*_to_mem`, `halt`). It owns PC, IR, Z and W, drives the single-cycle memory bus, and gates all bus activity while the core is halted. It also supplies IR to the decoder.

---
 rtl/sm83_bus_unit_if.sv | 52 +++++
 rtl/sm83_bus_unit.sv | 194 +++++++++++++++++++
 tb/tb_sm83_bus_unit.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm83_bus_unit_if.sv
// ---------------------------------------------------------------------------
// sm83_bus_pkg / sm83_bus_unit_if
//
// Purpose : shared types for the SM83 bus unit, and the single-cycle memory
//           bus interface that the unit drives.
//
// Interface signals:
//   mem_addr   16  address (driven by the bus unit)
//   mem_wdata   8  write data (driven by the bus unit)
//   mem_we      1  write enable (driven by the bus unit)
//   mem_re      1  read enable (driven by the bus unit)
//   mem_rdata   8  read data, valid in the same cycle as the address (memory)
//
// Modports: master = bus unit side, slave = memory side.
// ---------------------------------------------------------------------------
package sm83_bus_pkg;

    // Address source selected by the control sequencer.
    typedef enum logic [1:0] {
        SEL_PC   = 2'd0,
        SEL_GP16 = 2'd1,
        SEL_WZ   = 2'd2,
        SEL_FF_C = 2'd3
    } addr_sel_t;

endpackage

interface sm83_bus_unit_if;

    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );

endinterface

// File: rtl/sm83_bus_unit.sv
// ---------------------------------------------------------------------------
// sm83_bus_unit
//
// Purpose : bus and fetch unit of the SM83 core. Owns PC, IR, Z and W,
//           drives the single-cycle memory bus from the control sequencer's
//           per-cycle strobes, and gates all bus activity while halted.
//
// Ports:
//   clk, rst_n         core clock, asynchronous active-low reset
//   addr_sel_i         address source (PC, GP16, WZ, FF_C)
//   inc_pc_i           advance PC by one (wraps at 16 bits)
//   mem_to_z_i/_w_i/_ir_i  load Z / W / IR from the read byte
//   r8_to_mem_i        write r8_data_i to memory
//   z_to_mem_i         write Z to memory (wins over r8_to_mem_i)
//   halt_i, wake_i     halt request level, interrupt-pending level
//   gp16_i, r8_data_i, c_reg_i  register file operands
//   bus                memory bus (master side)
//   pc_o, ir_o, z_o, w_o        architectural registers
//   halted_o           high while in HALTED
//   halt_release_o     one-cycle pulse in RELEASE
//   protocol_err_o     sticky: conflicting strobes were seen
// ---------------------------------------------------------------------------
module sm83_bus_unit
    import sm83_bus_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  addr_sel_t             addr_sel_i,
    input  logic                  inc_pc_i,
    input  logic                  mem_to_z_i,
    input  logic                  mem_to_w_i,
    input  logic                  mem_to_ir_i,
    input  logic                  r8_to_mem_i,
    input  logic                  z_to_mem_i,
    input  logic                  halt_i,
    input  logic                  wake_i,
    input  logic [15:0]           gp16_i,
    input  logic [7:0]            r8_data_i,
    input  logic [7:0]            c_reg_i,

    sm83_bus_unit_if.master       bus,

    output logic [15:0]           pc_o,
    output logic [7:0]            ir_o,
    output logic [7:0]            z_o,
    output logic [7:0]            w_o,
    output logic                  halted_o,
    output logic                  halt_release_o,
    output logic                  protocol_err_o
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HALTED  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [7:0] IR_NOP = 8'h00;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  z_q, z_d;
    logic [7:0]  w_q, w_d;
    logic        err_q, err_d;

    logic        en;
    logic        wr_r8;
    logic        wr_z;
    logic        wr_any;
    logic        rd_any;
    logic        ld_ok;

    // ------------------------------------------------------------------
    // Strobe qualification. rst_n is folded in so the bus is quiet and
    // points at RESET_PC for as long as reset is held, not just after it.
    // ------------------------------------------------------------------
    assign en     = (state_q == ST_RUN) && rst_n;
    assign wr_r8  = en && r8_to_mem_i;
    assign wr_z   = en && z_to_mem_i;
    assign wr_any = wr_r8 || wr_z;
    assign rd_any = en && (mem_to_z_i || mem_to_w_i || mem_to_ir_i);

    // A write in the same cycle as a read owns the bus; reads are dropped.
    assign ld_ok  = rd_any && !wr_any;

    // ------------------------------------------------------------------
    // Memory bus (zero latency from the strobes)
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path through the block leaves it unassigned (no latch).
        bus.mem_addr = pc_q;
        if (en) begin
            unique case (addr_sel_i)
                SEL_PC:   bus.mem_addr = pc_q;
                SEL_GP16: bus.mem_addr = gp16_i;
                SEL_WZ:   bus.mem_addr = {w_q, z_q};
                SEL_FF_C: bus.mem_addr = {8'hFF, c_reg_i};
                default:  bus.mem_addr = pc_q;
            endcase
        end
    end

    assign bus.mem_we    = wr_any;
    assign bus.mem_re    = ld_ok;
    assign bus.mem_wdata = wr_z ? z_q : r8_data_i;

    // ------------------------------------------------------------------
    // Register next-state
    // ------------------------------------------------------------------
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        z_d   = z_q;
        w_d   = w_q;
        err_d = err_q;

        if (en && inc_pc_i) begin
            pc_d = pc_q + 16'd1;
        end

        // All loads in one cycle take the same byte.
        if (ld_ok && mem_to_z_i) begin
            z_d = bus.mem_rdata;
        end
        if (ld_ok && mem_to_w_i) begin
            w_d = bus.mem_rdata;
        end
        if (ld_ok && mem_to_ir_i) begin
            ir_d = bus.mem_rdata;
        end

        // Read/write overlap or double write source: flag and keep it.
        if ((wr_any && rd_any) || (wr_r8 && wr_z)) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Halt FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                // wake without halt is ignored here and not remembered.
                if (halt_i) begin
                    state_d = wake_i ? ST_RELEASE : ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (wake_i) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            ir_q    <= IR_NOP;
            z_q     <= 8'h00;
            w_q     <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            w_q     <= w_d;
            err_q   <= err_d;
        end
    end

    assign pc_o           = pc_q;
    assign ir_o           = ir_q;
    assign z_o            = z_q;
    assign w_o            = w_q;
    assign halted_o       = (state_q == ST_HALTED);
    assign halt_release_o = (state_q == ST_RELEASE);
    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_sm83_bus_unit.sv
// ---------------------------------------------------------------------------
// tb_sm83_bus_unit
//
// Directed stimulus for sm83_bus_unit (RESET_PC = 16'h0100). Each driven
// cycle pushes the hand-computed expected bus outputs and register values
// for that cycle into a scoreboard queue; a monitor pops and compares on the
// falling edge. A second instance with RESET_PC = 16'hFFFF covers PC wrap.
// ---------------------------------------------------------------------------
module tb_sm83_bus_unit;
    import sm83_bus_pkg::*;

    // Stimulus flag bits
    localparam logic [7:0] F_INC  = 8'h01;
    localparam logic [7:0] F_MZ   = 8'h02;
    localparam logic [7:0] F_MW   = 8'h04;
    localparam logic [7:0] F_MIR  = 8'h08;
    localparam logic [7:0] F_R8M  = 8'h10;
    localparam logic [7:0] F_ZM   = 8'h20;
    localparam logic [7:0] F_HALT = 8'h40;
    localparam logic [7:0] F_WAKE = 8'h80;

    typedef struct {
        logic        rst_n;
        addr_sel_t   sel;
        logic [7:0]  fl;
        logic [15:0] gp16;
        logic [7:0]  r8;
        logic [7:0]  c;
        logic [7:0]  rdata;
    } stim_t;

    typedef struct {
        int          idx;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic        re;
        logic [15:0] pc;
        logic [7:0]  ir;
        logic [7:0]  z;
        logic [7:0]  w;
        logic        halted;
        logic        rel;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    addr_sel_t   addr_sel;
    logic        inc_pc, mem_to_z, mem_to_w, mem_to_ir, r8_to_mem, z_to_mem;
    logic        halt, wake;
    logic [15:0] gp16;
    logic [7:0]  r8_data, c_reg;
    logic [15:0] pc;
    logic [7:0]  ir, z, w;
    logic        halted, halt_release, protocol_err;

    sm83_bus_unit_if bus_if ();

    sm83_bus_unit #(.RESET_PC(16'h0100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .addr_sel_i     (addr_sel),
        .inc_pc_i       (inc_pc),
        .mem_to_z_i     (mem_to_z),
        .mem_to_w_i     (mem_to_w),
        .mem_to_ir_i    (mem_to_ir),
        .r8_to_mem_i    (r8_to_mem),
        .z_to_mem_i     (z_to_mem),
        .halt_i         (halt),
        .wake_i         (wake),
        .gp16_i         (gp16),
        .r8_data_i      (r8_data),
        .c_reg_i        (c_reg),
        .bus            (bus_if),
        .pc_o           (pc),
        .ir_o           (ir),
        .z_o            (z),
        .w_o            (w),
        .halted_o       (halted),
        .halt_release_o (halt_release),
        .protocol_err_o (protocol_err)
    );

    // PC-wrap instance
    logic        wr_rst_n;
    logic        wr_inc;
    logic [15:0] wr_pc;
    logic [7:0]  wr_ir, wr_z, wr_w;
    logic        wr_halted, wr_rel, wr_err;

    sm83_bus_unit_if wrap_if ();

    sm83_bus_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk            (clk),
        .rst_n          (wr_rst_n),
        .addr_sel_i     (SEL_PC),
        .inc_pc_i       (wr_inc),
        .mem_to_z_i     (1'b0),
        .mem_to_w_i     (1'b0),
        .mem_to_ir_i    (1'b0),
        .r8_to_mem_i    (1'b0),
        .z_to_mem_i     (1'b0),
        .halt_i         (1'b0),
        .wake_i         (1'b0),
        .gp16_i         (16'h0000),
        .r8_data_i      (8'h00),
        .c_reg_i        (8'h00),
        .bus            (wrap_if),
        .pc_o           (wr_pc),
        .ir_o           (wr_ir),
        .z_o            (wr_z),
        .w_o            (wr_w),
        .halted_o       (wr_halted),
        .halt_release_o (wr_rel),
        .protocol_err_o (wr_err)
    );

    assign wrap_if.mem_rdata = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_idx = 0;
    exp_t sb[$];

    task automatic check(input string name, input int idx,
                         input logic [15:0] act, input logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp_v);
        end
    endtask

    function automatic stim_t st(input addr_sel_t sel, input logic [7:0] fl,
                                 input logic [15:0] g, input logic [7:0] r8,
                                 input logic [7:0] c, input logic [7:0] rd);
        stim_t s;
        s.rst_n = 1'b1;
        s.sel   = sel;
        s.fl    = fl;
        s.gp16  = g;
        s.r8    = r8;
        s.c     = c;
        s.rdata = rd;
        return s;
    endfunction

    function automatic exp_t ex(input logic [15:0] a, input logic [7:0] wd,
                                input logic we_v, input logic re_v,
                                input logic [15:0] pc_v, input logic [7:0] ir_v,
                                input logic [7:0] z_v, input logic [7:0] w_v,
                                input logic h_v, input logic r_v, input logic e_v);
        exp_t e;
        e.idx = 0;   e.addr = a;   e.wdata = wd; e.we = we_v; e.re = re_v;
        e.pc = pc_v; e.ir = ir_v;  e.z = z_v;    e.w = w_v;
        e.halted = h_v; e.rel = r_v; e.err = e_v;
        return e;
    endfunction

    // Drive one cycle just after the rising edge and queue its expectation.
    task automatic step(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        rst_n            = s.rst_n;
        addr_sel         = s.sel;
        inc_pc           = s.fl[0];
        mem_to_z         = s.fl[1];
        mem_to_w         = s.fl[2];
        mem_to_ir        = s.fl[3];
        r8_to_mem        = s.fl[4];
        z_to_mem         = s.fl[5];
        halt             = s.fl[6];
        wake             = s.fl[7];
        gp16             = s.gp16;
        r8_data          = s.r8;
        c_reg            = s.c;
        bus_if.mem_rdata = s.rdata;
        e.idx = step_idx;
        step_idx++;
        sb.push_back(e);
    endtask

    // Monitor: compare on the falling edge, away from the state update.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("mem_addr", e.idx, bus_if.mem_addr, e.addr);
                check("mem_we", e.idx, {15'd0, bus_if.mem_we}, {15'd0, e.we});
                check("mem_re", e.idx, {15'd0, bus_if.mem_re}, {15'd0, e.re});
                if (e.we) check("mem_wdata", e.idx, {8'd0, bus_if.mem_wdata}, {8'd0, e.wdata});
                check("pc", e.idx, pc, e.pc);
                check("ir", e.idx, {8'd0, ir}, {8'd0, e.ir});
                check("z", e.idx, {8'd0, z}, {8'd0, e.z});
                check("w", e.idx, {8'd0, w}, {8'd0, e.w});
                check("halted", e.idx, {15'd0, halted}, {15'd0, e.halted});
                check("halt_release", e.idx, {15'd0, halt_release}, {15'd0, e.rel});
                check("protocol_err", e.idx, {15'd0, protocol_err}, {15'd0, e.err});
            end
        end
    end

    initial begin
        stim_t s;
        int    budget;

        rst_n = 1'b0;  wr_rst_n = 1'b0;  wr_inc = 1'b0;
        addr_sel = SEL_PC;
        {inc_pc, mem_to_z, mem_to_w, mem_to_ir, r8_to_mem, z_to_mem, halt, wake} = '0;
        gp16 = '0; r8_data = '0; c_reg = '0; bus_if.mem_rdata = '0;

        // Reset held, strobes active: bus must stay quiet at RESET_PC.
        s = st(SEL_WZ, F_INC | F_MIR | F_R8M, 16'h0, 8'hAA, 8'h0, 8'h99); s.rst_n = 1'b0;
        step(s, ex(16'h0100, 8'h00, 0, 0, 16'h0100, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        step(s, ex(16'h0100, 8'h00, 0, 0, 16'h0100, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        wr_rst_n = 1'b1;

        // Immediate load: Z then IR, PC 0100 -> 0101 -> 0102
        step(st(SEL_PC, F_MZ | F_INC, 0, 0, 0, 8'h3C),
             ex(16'h0100, 0, 0, 1, 16'h0100, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        step(st(SEL_PC, F_MIR | F_INC, 0, 0, 0, 8'h06),
             ex(16'h0101, 0, 0, 1, 16'h0101, 8'h00, 8'h3C, 8'h00, 0, 0, 0));
        step(st(SEL_PC, 8'h00, 0, 0, 0, 0),
             ex(16'h0102, 0, 0, 0, 16'h0102, 8'h06, 8'h3C, 8'h00, 0, 0, 0));
        // Build WZ = 1234
        step(st(SEL_PC, F_MZ, 0, 0, 0, 8'h34),
             ex(16'h0102, 0, 0, 1, 16'h0102, 8'h06, 8'h3C, 8'h00, 0, 0, 0));
        step(st(SEL_PC, F_MW, 0, 0, 0, 8'h12),
             ex(16'h0102, 0, 0, 1, 16'h0102, 8'h06, 8'h34, 8'h00, 0, 0, 0));
        // Write addressing
        step(st(SEL_WZ, F_R8M, 0, 8'hAA, 0, 8'h5A),
             ex(16'h1234, 8'hAA, 1, 0, 16'h0102, 8'h06, 8'h34, 8'h12, 0, 0, 0));
        step(st(SEL_FF_C, 8'h00, 0, 0, 8'h80, 0),
             ex(16'hFF80, 0, 0, 0, 16'h0102, 8'h06, 8'h34, 8'h12, 0, 0, 0));
        step(st(SEL_GP16, F_ZM, 16'hC000, 8'h55, 0, 0),
             ex(16'hC000, 8'h34, 1, 0, 16'h0102, 8'h06, 8'h34, 8'h12, 0, 0, 0));
        // Multiple loads from one byte
        step(st(SEL_PC, F_MZ | F_MW | F_MIR, 0, 0, 0, 8'h77),
             ex(16'h0102, 0, 0, 1, 16'h0102, 8'h06, 8'h34, 8'h12, 0, 0, 0));
        step(st(SEL_PC, 8'h00, 0, 0, 0, 0),
             ex(16'h0102, 0, 0, 0, 16'h0102, 8'h77, 8'h77, 8'h77, 0, 0, 0));

        // Halt: strobes in the halt cycle still execute
        step(st(SEL_PC, F_HALT | F_INC | F_MIR, 0, 0, 0, 8'h11),
             ex(16'h0102, 0, 0, 1, 16'h0102, 8'h77, 8'h77, 8'h77, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            step(st(SEL_WZ, F_HALT | F_INC | F_MIR | (i == 2 ? F_R8M : 8'h00), 0, 8'hEE, 0, 8'h22),
                 ex(16'h0103, 0, 0, 0, 16'h0103, 8'h11, 8'h77, 8'h77, 1, 0, 0));
        end
        step(st(SEL_PC, F_WAKE | F_INC | F_MIR, 0, 0, 0, 8'h33),
             ex(16'h0103, 0, 0, 0, 16'h0103, 8'h11, 8'h77, 8'h77, 1, 0, 0));
        step(st(SEL_PC, F_INC | F_MIR, 0, 0, 0, 8'h44),
             ex(16'h0103, 0, 0, 0, 16'h0103, 8'h11, 8'h77, 8'h77, 0, 1, 0));
        step(st(SEL_PC, F_INC | F_MIR, 0, 0, 0, 8'h55),
             ex(16'h0103, 0, 0, 1, 16'h0103, 8'h11, 8'h77, 8'h77, 0, 0, 0));
        step(st(SEL_PC, 8'h00, 0, 0, 0, 0),
             ex(16'h0104, 0, 0, 0, 16'h0104, 8'h55, 8'h77, 8'h77, 0, 0, 0));

        // halt + wake together: straight to RELEASE
        step(st(SEL_PC, F_HALT | F_WAKE, 0, 0, 0, 0),
             ex(16'h0104, 0, 0, 0, 16'h0104, 8'h55, 8'h77, 8'h77, 0, 0, 0));
        step(st(SEL_PC, F_INC | F_MZ, 0, 0, 0, 8'h66),
             ex(16'h0104, 0, 0, 0, 16'h0104, 8'h55, 8'h77, 8'h77, 0, 1, 0));
        step(st(SEL_PC, F_INC, 0, 0, 0, 0),
             ex(16'h0104, 0, 0, 0, 16'h0104, 8'h55, 8'h77, 8'h77, 0, 0, 0));
        // wake alone in RUN is ignored
        step(st(SEL_PC, F_WAKE | F_INC, 0, 0, 0, 0),
             ex(16'h0105, 0, 0, 0, 16'h0105, 8'h55, 8'h77, 8'h77, 0, 0, 0));
        step(st(SEL_PC, 8'h00, 0, 0, 0, 0),
             ex(16'h0106, 0, 0, 0, 16'h0106, 8'h55, 8'h77, 8'h77, 0, 0, 0));

        // Read/write conflict: write wins, load dropped, PC still advances
        step(st(SEL_WZ, F_R8M | F_MZ | F_INC, 0, 8'hAA, 0, 8'h99),
             ex(16'h7777, 8'hAA, 1, 0, 16'h0106, 8'h55, 8'h77, 8'h77, 0, 0, 0));
        step(st(SEL_PC, 8'h00, 0, 0, 0, 0),
             ex(16'h0107, 0, 0, 0, 16'h0107, 8'h55, 8'h77, 8'h77, 0, 0, 1));
        step(st(SEL_PC, F_MIR, 0, 0, 0, 8'h01),
             ex(16'h0107, 0, 0, 1, 16'h0107, 8'h55, 8'h77, 8'h77, 0, 0, 1));

        // Reset mid-cycle from RUN with error set
        s = st(SEL_WZ, F_INC | F_MIR | F_R8M, 0, 8'hAA, 0, 8'h99); s.rst_n = 1'b0;
        step(s, ex(16'h0100, 0, 0, 0, 16'h0100, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        // Both write sources: Z wins and the error is flagged
        step(st(SEL_PC, F_ZM | F_R8M, 0, 8'hAA, 0, 0),
             ex(16'h0100, 8'h00, 1, 0, 16'h0100, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        step(st(SEL_PC, 8'h00, 0, 0, 0, 0),
             ex(16'h0100, 0, 0, 0, 16'h0100, 8'h00, 8'h00, 8'h00, 0, 0, 1));

        // Drain scoreboard with a bounded wait
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("scoreboard_drained", step_idx, sb.size(), 16'd0);

        // PC wrap on the second instance
        @(negedge clk);
        check("wrap_pc_before", 0, wr_pc, 16'hFFFF);
        check("wrap_addr_before", 0, wrap_if.mem_addr, 16'hFFFF);
        @(posedge clk); #1; wr_inc = 1'b1;
        @(posedge clk); #1; wr_inc = 1'b0;
        @(negedge clk);
        check("wrap_pc_after", 1, wr_pc, 16'h0000);
        check("wrap_err", 1, {15'd0, wr_err}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
